// File: rtl/testdrive_interrupt_gen.sv
// Interrupt source: captures rising edges on event lines into sticky pending bits,
// masks them, and drives a single INTR line as either a level or a paced pulse train.
module testdrive_interrupt_gen #(
    parameter int                   C_SOURCES     = 8,
    parameter int                   C_EDGE_DETECT = 1,
    parameter int                   C_ACTIVE      = 1,
    parameter int                   C_PULSE_WIDTH = 4,
    parameter int                   C_HOLDOFF     = 8,
    parameter logic [C_SOURCES-1:0] C_MASK_INIT   = '1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [C_SOURCES-1:0] SRC,
    input  logic                 MASK_WE,
    input  logic [C_SOURCES-1:0] MASK_WDATA,
    input  logic                 CLR_WE,
    input  logic [C_SOURCES-1:0] CLR_WDATA,
    output logic [C_SOURCES-1:0] PENDING,
    output logic [C_SOURCES-1:0] MASK,
    output logic                 INTR
);

    localparam logic INTR_ON  = (C_ACTIVE != 0) ? 1'b1 : 1'b0;
    localparam logic INTR_OFF = ~INTR_ON;

    logic [C_SOURCES-1:0] src_prev_reg;
    logic [C_SOURCES-1:0] pending_reg;
    logic [C_SOURCES-1:0] pending_next;
    logic [C_SOURCES-1:0] mask_reg;
    logic [C_SOURCES-1:0] mask_next;
    logic [C_SOURCES-1:0] act;
    logic                 intr_reg;

    // A new event beats a simultaneous clear of the same bit.
    genvar gi;
    generate
        for (gi = 0; gi < C_SOURCES; gi++) begin : g_src
            assign pending_next[gi] = (SRC[gi] & ~src_prev_reg[gi])
                                    | (pending_reg[gi] & ~(CLR_WE & CLR_WDATA[gi]));
        end
    endgenerate

    assign mask_next = MASK_WE ? MASK_WDATA : mask_reg;
    assign act       = pending_reg & mask_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            src_prev_reg <= '0;
            pending_reg  <= '0;
            mask_reg     <= C_MASK_INIT;
        end else begin
            src_prev_reg <= SRC;
            pending_reg  <= pending_next;
            mask_reg     <= mask_next;
        end
    end

    generate
        if (C_EDGE_DETECT != 0) begin : g_edge
            localparam int CNT_MAX = (C_PULSE_WIDTH > C_HOLDOFF) ? C_PULSE_WIDTH : C_HOLDOFF;
            localparam int CW      = $clog2(CNT_MAX + 1);
            localparam logic [CW-1:0] PW_LOAD   = CW'(C_PULSE_WIDTH - 1);
            localparam logic [CW-1:0] HOLD_LOAD = CW'((C_HOLDOFF > 0) ? (C_HOLDOFF - 1) : 0);

            typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

            state_t          state_reg;
            state_t          state_next;
            logic [CW-1:0]   cnt_reg;
            logic [CW-1:0]   cnt_next;
            logic            arm_reg;
            logic            arm_next;
            logic [C_SOURCES-1:0] act_d_reg;
            logic            en_d_reg;
            logic            new_any;

            // Re-enabling with work outstanding is treated like a fresh event.
            always_comb begin
                new_any    = EN && ((|(act & ~act_d_reg)) || (!en_d_reg && (|act)));
                state_next = state_reg;
                cnt_next   = cnt_reg;
                arm_next   = arm_reg | new_any;
                if (!EN) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    arm_next   = 1'b0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (arm_reg) begin
                                state_next = PULSE;
                                cnt_next   = PW_LOAD;
                                arm_next   = new_any;
                            end
                        end
                        PULSE: begin
                            if (cnt_reg == '0) begin
                                if (C_HOLDOFF > 0) begin
                                    state_next = GAP;
                                    cnt_next   = HOLD_LOAD;
                                end else begin
                                    state_next = IDLE;
                                end
                            end else begin
                                cnt_next = cnt_reg - CW'(1);
                            end
                        end
                        GAP: begin
                            // A coalesced burst fires right at the end of the holdoff.
                            if (cnt_reg == '0) begin
                                if (arm_reg) begin
                                    state_next = PULSE;
                                    cnt_next   = PW_LOAD;
                                    arm_next   = new_any;
                                end else begin
                                    state_next = IDLE;
                                end
                            end else begin
                                cnt_next = cnt_reg - CW'(1);
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    arm_reg   <= 1'b0;
                    act_d_reg <= '0;
                    en_d_reg  <= 1'b0;
                    intr_reg  <= INTR_OFF;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    arm_reg   <= arm_next;
                    act_d_reg <= act;
                    en_d_reg  <= EN;
                    intr_reg  <= (state_next == PULSE) ? INTR_ON : INTR_OFF;
                end
            end
        end else begin : g_level
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    intr_reg <= INTR_OFF;
                end else begin
                    intr_reg <= (EN && (|act)) ? INTR_ON : INTR_OFF;
                end
            end
        end
    endgenerate

    assign PENDING = pending_reg;
    assign MASK    = mask_reg;
    assign INTR    = intr_reg;

endmodule

// File: tb/tb_testdrive_interrupt_gen.sv
// Bench for testdrive_interrupt_gen: edge/active-high, level/active-high and
// edge/active-low instances share one directed stimulus; a scoreboard checks every cycle.
module tb_testdrive_interrupt_gen;

    localparam int S_P = 0;
    localparam int S_M = 1;
    localparam int S_A = 2;
    localparam int S_L = 3;
    localparam int LAST_CYC = 135;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [7:0] SRC;
    logic       MASK_WE;
    logic [7:0] MASK_WDATA;
    logic       CLR_WE;
    logic [7:0] CLR_WDATA;

    logic [7:0] pend_a, mask_a, pend_b, mask_b, pend_c, mask_c;
    logic       intr_a, intr_b, intr_c;

    always #5 CLK = ~CLK;

    testdrive_interrupt_gen u_a (
        .CLK(CLK), .RST(RST), .EN(EN), .SRC(SRC),
        .MASK_WE(MASK_WE), .MASK_WDATA(MASK_WDATA),
        .CLR_WE(CLR_WE), .CLR_WDATA(CLR_WDATA),
        .PENDING(pend_a), .MASK(mask_a), .INTR(intr_a)
    );

    testdrive_interrupt_gen #(.C_EDGE_DETECT(0)) u_b (
        .CLK(CLK), .RST(RST), .EN(EN), .SRC(SRC),
        .MASK_WE(MASK_WE), .MASK_WDATA(MASK_WDATA),
        .CLR_WE(CLR_WE), .CLR_WDATA(CLR_WDATA),
        .PENDING(pend_b), .MASK(mask_b), .INTR(intr_b)
    );

    testdrive_interrupt_gen #(.C_ACTIVE(0)) u_c (
        .CLK(CLK), .RST(RST), .EN(EN), .SRC(SRC),
        .MASK_WE(MASK_WE), .MASK_WDATA(MASK_WDATA),
        .CLR_WE(CLR_WE), .CLR_WDATA(CLR_WDATA),
        .PENDING(pend_c), .MASK(mask_c), .INTR(intr_c)
    );

    typedef struct {
        int         c;
        int         sig;
        logic [7:0] v;
    } chg_t;

    typedef struct {
        int         c;
        logic [7:0] p;
        logic [7:0] m;
        logic       ia;
        logic       il;
    } exp_t;

    chg_t chg_q[$];
    exp_t sb_q[$];
    exp_t mon_x;
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input int c, input int sig, input logic [7:0] v);
        chg_t x;
        x.c   = c;
        x.sig = sig;
        x.v   = v;
        chg_q.push_back(x);
    endtask

    // Expected values are piecewise constant; the change table is hand-derived.
    function automatic exp_t expected_at(input int e);
        exp_t       x;
        logic [7:0] v;
        x.c  = e;
        x.p  = 8'h00;
        x.m  = 8'hFF;
        x.ia = 1'b0;
        x.il = 1'b0;
        foreach (chg_q[i]) begin
            if (chg_q[i].c <= e) begin
                v = chg_q[i].v;
                case (chg_q[i].sig)
                    S_P:     x.p  = v;
                    S_M:     x.m  = v;
                    S_A:     x.ia = v[0];
                    default: x.il = v[0];
                endcase
            end
        end
        return x;
    endfunction

    task automatic check8(input string name, input int c, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
        end
    endtask

    // Inputs for the clock edge numbered e (pulses on MASK_WE/CLR_WE last one edge).
    task automatic apply(input int e);
        MASK_WE = 1'b0;
        CLR_WE  = 1'b0;
        case (e)
            10:  SRC = 8'h01;
            13:  SRC = 8'h03;
            40:  begin CLR_WE = 1'b1; CLR_WDATA = 8'h03; end
            42:  SRC = 8'h00;
            44:  begin SRC = 8'h08; CLR_WE = 1'b1; CLR_WDATA = 8'h08; end
            60:  begin CLR_WE = 1'b1; CLR_WDATA = 8'h08; end
            62:  begin MASK_WE = 1'b1; MASK_WDATA = 8'h00; end
            64:  SRC = 8'h28;
            70:  begin MASK_WE = 1'b1; MASK_WDATA = 8'h20; end
            86:  begin MASK_WE = 1'b1; MASK_WDATA = 8'hFF; CLR_WE = 1'b1; CLR_WDATA = 8'h20; end
            88:  SRC = 8'h00;
            90:  SRC = 8'h80;
            93:  EN = 1'b0;
            97:  EN = 1'b1;
            112: begin SRC = 8'h40; MASK_WE = 1'b1; MASK_WDATA = 8'h7F; end
            default: ;
        endcase
    endtask

    // Monitor: every cycle's outputs are compared at the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            while (sb_q.size() > 0) begin
                mon_x = sb_q.pop_front();
                check8("pending_a", mon_x.c, pend_a, mon_x.p);
                check8("pending_b", mon_x.c, pend_b, mon_x.p);
                check8("pending_c", mon_x.c, pend_c, mon_x.p);
                check8("mask_a", mon_x.c, mask_a, mon_x.m);
                check8("mask_b", mon_x.c, mask_b, mon_x.m);
                check8("mask_c", mon_x.c, mask_c, mon_x.m);
                check8("intr_edge_hi", mon_x.c, {7'd0, intr_a}, {7'd0, mon_x.ia});
                check8("intr_level_hi", mon_x.c, {7'd0, intr_b}, {7'd0, mon_x.il});
                check8("intr_edge_lo", mon_x.c, {7'd0, intr_c}, {7'd0, ~mon_x.ia});
                $display("cyc=%0d pending=%h mask=%h intr edge/level/low=%b%b%b",
                         mon_x.c, pend_a, mask_a, intr_a, intr_b, intr_c);
            end
        end
    end

    initial begin
        RST        = 1'b1;
        EN         = 1'b1;
        SRC        = 8'h00;
        MASK_WE    = 1'b0;
        MASK_WDATA = 8'h00;
        CLR_WE     = 1'b0;
        CLR_WDATA  = 8'h00;

        // Edge mode: event at edge k -> PENDING after k, pulse after k+2.
        add(10, S_P, 8'h01); add(11, S_L, 8'h01); add(12, S_A, 8'h01);
        add(13, S_P, 8'h03); add(16, S_A, 8'h00);
        add(24, S_A, 8'h01); add(28, S_A, 8'h00);
        add(40, S_P, 8'h00); add(41, S_L, 8'h00);
        // Set/clear collision keeps the bit set.
        add(44, S_P, 8'h08); add(45, S_L, 8'h01); add(46, S_A, 8'h01); add(50, S_A, 8'h00);
        add(60, S_P, 8'h00); add(61, S_L, 8'h00);
        // Masked event stays silent until the mask opens.
        add(62, S_M, 8'h00); add(64, S_P, 8'h20);
        add(70, S_M, 8'h20); add(71, S_L, 8'h01); add(72, S_A, 8'h01); add(76, S_A, 8'h00);
        add(86, S_M, 8'hFF); add(86, S_P, 8'h00); add(87, S_L, 8'h00);
        // EN drop mid-pulse, then re-enable with pending work.
        add(90, S_P, 8'h80); add(91, S_L, 8'h01); add(92, S_A, 8'h01);
        add(93, S_A, 8'h00); add(93, S_L, 8'h00);
        add(97, S_L, 8'h01); add(98, S_A, 8'h01); add(102, S_A, 8'h00);
        // Async reset during a pulse, then SRC already high counts as an event.
        add(112, S_P, 8'hC0); add(112, S_M, 8'h7F); add(114, S_A, 8'h01);
        add(115, S_P, 8'h00); add(115, S_M, 8'hFF); add(115, S_A, 8'h00); add(115, S_L, 8'h00);
        add(117, S_P, 8'h40); add(118, S_L, 8'h01); add(119, S_A, 8'h01); add(123, S_A, 8'h00);

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        sb_q.push_back(expected_at(0));

        for (int e = 1; e <= LAST_CYC; e++) begin
            apply(e);
            @(posedge CLK);
            #1;
            sb_q.push_back(expected_at(e));
            if (e == 115) begin
                #2;
                RST = 1'b1;
            end
            if (e == 116) begin
                RST = 1'b0;
            end
        end

        @(negedge CLK);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
